// File: rtl/pe_group_mac.sv
// pe_group_mac: TAPS-lane signed MAC with multi-beat group accumulation,
// shift/saturate/ReLU requantisation and a valid/ready result port.
module pe_group_mac #(
    parameter int TAPS  = 5,
    parameter int DW    = 8,
    parameter int OW    = 11,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [TAPS*DW-1:0]   ifmap,
    input  logic [TAPS*DW-1:0]   weight,
    input  logic [4:0]           shift,
    input  logic                 relu_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic                 idle,
    output logic                 done
);

    localparam int SW = 2 * DW + $clog2(TAPS);

    localparam logic signed [ACC_W-1:0] OMAX =
        {{(ACC_W - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    logic                    en;
    logic                    load;

    logic                    v1;
    logic                    last1;
    logic                    relu1;
    logic [4:0]              sh1;
    logic signed [2*DW-1:0]  prod1 [TAPS];

    logic                    v2;
    logic                    last2;
    logic                    relu2;
    logic [4:0]              sh2;
    logic signed [SW-1:0]    sum2;
    logic signed [SW-1:0]    sum_c;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] tot;
    logic signed [ACC_W-1:0] shr;
    logic [OW-1:0]           res;

    logic                    nv1;
    logic                    nv2;
    logic                    nov;
    logic                    idle_nxt;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign load     = en && v2 && last2;
    assign idle     = !(v1 || v2 || out_valid);

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_c = sum_c + SW'(prod1[i]);
        end
    end

    assign tot = acc + ACC_W'(sum2);
    assign shr = tot >>> sh2;

    always_comb begin
        if (shr > OMAX) begin
            res = OMAX[OW-1:0];
        end else if (shr < OMIN) begin
            res = OMIN[OW-1:0];
        end else begin
            res = shr[OW-1:0];
        end
        if (relu2 && shr[ACC_W-1]) begin
            res = '0;
        end
    end

    // Look-ahead of idle so done lands in the first idle cycle.
    always_comb begin
        nv1      = en ? in_valid : v1;
        nv2      = en ? v1 : v2;
        nov      = load || (out_valid && !out_ready);
        idle_nxt = !(nv1 || nv2 || nov);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            relu1 <= 1'b0;
            sh1   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                prod1[i] <= '0;
            end
        end else if (clear) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1    <= in_valid;
            last1 <= in_last;
            relu1 <= relu_en;
            sh1   <= shift;
            for (int i = 0; i < TAPS; i++) begin
                prod1[i] <= $signed(ifmap[i*DW +: DW])
                          * $signed(weight[i*DW +: DW]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            relu2 <= 1'b0;
            sh2   <= '0;
            sum2  <= '0;
        end else if (clear) begin
            v2 <= 1'b0;
        end else if (en) begin
            v2    <= v1;
            last2 <= last1;
            relu2 <= relu1;
            sh2   <= sh1;
            sum2  <= sum_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= !idle && idle_nxt;
            if (en && v2) begin
                acc <= last2 ? '0 : tot;
            end
            if (load) begin
                out_data  <= res;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_group_mac.sv
// tb_pe_group_mac: directed scenarios plus randomized traffic checked
// against a group-level dot-product/requantise model.
module tb_pe_group_mac;

    localparam int TAPS  = 5;
    localparam int DW    = 8;
    localparam int OW    = 11;
    localparam int ACC_W = 24;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clear = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_last = 1'b0;
    logic [TAPS*DW-1:0]  ifmap = '0;
    logic [TAPS*DW-1:0]  weight = '0;
    logic [4:0]          shift = '0;
    logic                relu_en = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [OW-1:0]       out_data;
    logic                idle;
    logic                done;

    pe_group_mac #(
        .TAPS(TAPS), .DW(DW), .OW(OW), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .ifmap(ifmap), .weight(weight),
        .shift(shift), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .idle(idle), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    longint exp_q[$];
    longint m_acc = 0;
    int     grp = 0;
    bit     prev_stall = 1'b0;
    bit     prev_clr = 1'b0;
    logic [OW-1:0] prev_data = '0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint dot(input logic [TAPS*DW-1:0] a,
                                   input logic [TAPS*DW-1:0] b);
        longint s = 0;
        for (int i = 0; i < TAPS; i++) begin
            s += longint'($signed(a[i*DW +: DW]))
               * longint'($signed(b[i*DW +: DW]));
        end
        return s;
    endfunction

    function automatic longint requant(input longint t, input int sh,
                                       input bit relu);
        longint hi = (longint'(1) <<< (OW - 1)) - 1;
        longint r = t >>> sh;
        if (r > hi) r = hi;
        else if (r < -hi - 1) r = -hi - 1;
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    function automatic logic [TAPS*DW-1:0] rep(input int v);
        logic [TAPS*DW-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    // Reference model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_acc = 0;
            grp = 0;
            prev_stall = 1'b0;
            prev_clr = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (prev_clr) begin
                chk("clr_done", done, 0);
                chk("clr_valid", out_valid, 0);
            end
            if (done) chk("done_idle", idle, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    chk("result", $signed(out_data), exp_q.pop_front());
                end
            end
            if (clear) begin
                exp_q.delete();
                m_acc = 0;
                grp = 0;
            end else if (in_valid && in_ready) begin
                m_acc += dot(ifmap, weight);
                if (in_last) begin
                    exp_q.push_back(requant(m_acc, int'(shift), relu_en));
                    m_acc = 0;
                    grp = 0;
                end else begin
                    grp++;
                end
            end
            prev_stall = out_valid && !out_ready && !clear;
            prev_clr = clear;
            prev_data = out_data;
        end
    end

    task automatic send(input int a, input int b, input bit last,
                        input int sh, input bit relu);
        int k = 0;
        ifmap = rep(a);
        weight = rep(b);
        in_last = last;
        shift = 5'(sh);
        relu_en = relu;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(input string nm, input longint exp);
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid"}, out_valid, 1);
        chk(nm, $signed(out_data), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(10, 3, 1, 0, 0);
        @(negedge clk);
        chk("lat1", out_valid, 0);
        @(negedge clk);
        chk("lat2", out_valid, 0);
        @(negedge clk);
        chk("lat3", out_valid, 1);
        chk("single150", $signed(out_data), 150);
        chk("done_early", done, 0);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("idle_after", idle, 1);
        @(negedge clk);
        chk("done_once", done, 0);
        @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++) begin
            send(127, 127, 0, 0, 0);
            send(127, 127, 0, 0, 0);
            send(127, 127, 1, s == 0 ? 10 : 7, 0);
            wait_out(s == 0 ? "three_sh10" : "three_sat", s == 0 ? 236 : 1023);
        end

        send(-128, 127, 1, 7, 0);
        wait_out("neg_sh7", -635);
        send(-128, 127, 1, 7, 1);
        wait_out("neg_relu", 0);
        send(-128, 127, 1, 0, 0);
        wait_out("neg_sat", -1024);

        out_ready = 1'b0;
        send(10, 3, 1, 0, 0);
        send(1, 1, 1, 0, 0);
        wait_out("stall_first", 150);
        chk("stall_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", $signed(out_data), 150);
            chk("stall_rdy", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs1", $signed(out_data), 150);
        @(negedge clk);
        chk("stall_hs2v", out_valid, 1);
        chk("stall_hs2", $signed(out_data), 5);
        @(negedge clk);
        chk("stall_empty", out_valid, 0);
        @(posedge clk);
        #1;

        send(10, 3, 0, 0, 0);
        send(10, 3, 0, 0, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_idle", idle, 1);
        chk("clr_nodone", done, 0);
        @(negedge clk);
        chk("clr_nodone2", done, 0);
        @(posedge clk);
        #1;
        send(1, 2, 1, 0, 0);
        wait_out("after_clear", 10);

        repeat (3) @(posedge clk);
        #1;
        send(10, 3, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_done", done, 0);
        chk("mrst_idle", idle, 1);
        chk("mrst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(10, 3, 1, 0, 0);
        wait_out("after_rst", 150);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid = $urandom_range(0, 3) != 0;
            for (int i = 0; i < TAPS; i++) begin
                ifmap[i*DW +: DW] = DW'($urandom);
                weight[i*DW +: DW] = DW'($urandom);
            end
            in_last = ($urandom_range(0, 3) == 0) || grp >= 10;
            shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'($urandom_range(6, 14));
            relu_en = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 9) < 7;
            clear = $urandom_range(0, 49) == 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
